// File: rtl/pipelined_barrel_shifter_pkg.sv
// barrel_shifter_pkg
//   Shared types for the pipelined barrel shifter.
//   - shift_op_t      : operation encoding carried down the pipe
//   - stage_payload_t : everything one pipeline stage holds besides its valid bit
//   - stage_shift()   : power-of-two shift applied by a given stage (largest first)
//   The payload struct is sized by the PKG_* localparams below. The top-level
//   N / TAG_W parameters default to these values, so a different datapath
//   width is selected here rather than by overriding the top alone.
package barrel_shifter_pkg;

   localparam int PKG_N     = 32;
   localparam int PKG_TAG_W = 4;
   localparam int PKG_LOG2N = $clog2(PKG_N);

   typedef enum logic [1:0] {
      SH_SRL = 2'b00,
      SH_SLL = 2'b01,
      SH_SRA = 2'b10,
      SH_ROR = 2'b11
   } shift_op_t;

   // sign is the operand MSB captured on entry; arithmetic shifts fill from
   // it at every stage, so it must travel with the data rather than being
   // re-derived from partially shifted data.
   typedef struct packed {
      logic [PKG_N-1:0]     data;
      logic [PKG_LOG2N-1:0] shamt;
      shift_op_t            op;
      logic                 sign;
      logic [PKG_TAG_W-1:0] tag;
   } stage_payload_t;

   // Stage k of a log2n-deep pipe handles shift-amount bit (log2n-1-k).
   function automatic int stage_shift(input int log2n, input int k);
      return 1 << (log2n - 1 - k);
   endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// shift_stage
//   One level of the pipelined barrel shifter: a payload register with a
//   valid bit and local ready, followed by a combinational mux row that
//   applies this stage's fixed power-of-two shift when the matching bit of
//   the carried shift amount is set.
//   Optional feature: `BARREL_ROTATE_EN builds the rotate-right path; when it
//   is undefined, SH_ROR falls through to the logical right shift.
// Parameters
//   N      data width
//   TAG_W  sideband tag width
//   SHIFT  power-of-two shift amount for this stage
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   up_valid / up_ready  handshake with the previous stage (or the block input)
//   down_ready           ready of the next stage (or the block consumer)
//   valid                this stage holds an operation
//   *_in                 payload offered by the previous stage
//   *_out                this stage's payload with its shift applied
module shift_stage
   import barrel_shifter_pkg::*;
#(
   parameter int N     = PKG_N,
   parameter int TAG_W = PKG_TAG_W,
   parameter int SHIFT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic                 down_ready,
   output logic                 valid,
   input  logic [N-1:0]         data_in,
   input  logic [$clog2(N)-1:0] shamt_in,
   input  shift_op_t            op_in,
   input  logic                 sign_in,
   input  logic [TAG_W-1:0]     tag_in,
   output logic [N-1:0]         data_out,
   output logic [$clog2(N)-1:0] shamt_out,
   output shift_op_t            op_out,
   output logic                 sign_out,
   output logic [TAG_W-1:0]     tag_out
);

   localparam int SEL = $clog2(SHIFT);

   stage_payload_t stage_q;
   logic           valid_q;
   logic           local_ready;
   logic [N-1:0]   shifted;

   // An empty stage always accepts, so bubbles collapse even while the
   // consumer is stalled; a full stage only moves when downstream moves.
   assign local_ready = !valid_q || down_ready;
   assign up_ready    = local_ready;
   assign valid       = valid_q;

   // Payload/valid register. A full stage that cannot advance keeps
   // everything, which keeps the block outputs stable under backpressure.
   // Payload only loads on a real operation so bubbles do not toggle data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         stage_q <= '0;
      end else if (local_ready) begin
         valid_q <= up_valid;
         if (up_valid) begin
            stage_q.data  <= data_in;
            stage_q.shamt <= shamt_in;
            stage_q.op    <= op_in;
            stage_q.sign  <= sign_in;
            stage_q.tag   <= tag_in;
         end
      end
   end

   // Mux row for every mode. With all-zero data after reset each branch
   // yields zero, which is what keeps Result at 0 coming out of reset.
   always_comb begin
      shifted = stage_q.data;
      if (stage_q.shamt[SEL]) begin
         case (stage_q.op)
            SH_SLL:  shifted = stage_q.data << SHIFT;
            SH_SRA:  shifted = {{SHIFT{stage_q.sign}}, stage_q.data[N-1:SHIFT]};
`ifdef BARREL_ROTATE_EN
            SH_ROR:  shifted = {stage_q.data[SHIFT-1:0], stage_q.data[N-1:SHIFT]};
`endif
            default: shifted = stage_q.data >> SHIFT;
         endcase
      end
   end

   assign data_out  = shifted;
   assign shamt_out = stage_q.shamt;
   assign op_out    = stage_q.op;
   assign sign_out  = stage_q.sign;
   assign tag_out   = stage_q.tag;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Multi-mode (SRL/SLL/SRA/ROR) barrel shifter with one register stage per
//   shift level and valid/ready handshakes on both sides. Throughput is one
//   operation per cycle; an operation accepted on edge t is presented on
//   Out_Valid after edge t+LOG2N-1.
//   Optional feature: `BARREL_ROTATE_EN enables rotate-right for Op = 11;
//   without it Op = 11 behaves exactly as SRL.
// Parameters
//   N      data width (power of two, >= 4)
//   TAG_W  sideband tag width
//   LOG2N  shift-amount width and pipeline depth (derived)
// Ports
//   Clk, Reset           clock, asynchronous active-high reset
//   In_Valid / In_Ready  input handshake (In_Ready is combinational)
//   Input, Shift_Val     operand and shift amount 0..N-1
//   Op                   00 SRL, 01 SLL, 10 SRA, 11 ROR
//   In_Tag               opaque tag returned with the result
//   Out_Valid/Out_Ready  output handshake
//   Result, Out_Tag      shifted operand and its tag
//   Zero                 Result == 0 for a valid result, else 0
module pipelined_barrel_shifter
   import barrel_shifter_pkg::*;
#(
   parameter int  N     = PKG_N,
   parameter int  TAG_W = PKG_TAG_W,
   localparam int LOG2N = $clog2(N)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [N-1:0]     Input,
   input  logic [LOG2N-1:0] Shift_Val,
   input  logic [1:0]       Op,
   input  logic [TAG_W-1:0] In_Tag,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [N-1:0]     Result,
   output logic [TAG_W-1:0] Out_Tag,
   output logic             Zero
);

   // Element 0 is the block input; element k+1 is what stage k presents.
   logic             valid_s [LOG2N+1];
   logic [N-1:0]     data_s  [LOG2N+1];
   logic [LOG2N-1:0] shamt_s [LOG2N+1];
   shift_op_t        op_s    [LOG2N+1];
   logic             sign_s  [LOG2N+1];
   logic [TAG_W-1:0] tag_s   [LOG2N+1];

   // Input capture: the operand MSB is taken here as the SRA fill value.
   assign valid_s[0] = In_Valid;
   assign data_s[0]  = Input;
   assign shamt_s[0] = Shift_Val;
   assign op_s[0]    = shift_op_t'(Op);
   assign sign_s[0]  = Input[N-1];
   assign tag_s[0]   = In_Tag;

   // Stage chain, largest shift first. Each stage's ready lives in its own
   // generate scope so the backward ready chain is a plain wire chain.
   for (genvar k = 0; k < LOG2N; k++) begin : g_stage
      logic up_ready;
      logic down_ready;

      if (k == LOG2N - 1) begin : g_tail
         assign down_ready = Out_Ready;
      end else begin : g_link
         assign down_ready = g_stage[k+1].up_ready;
      end

      shift_stage #(
         .N     (N),
         .TAG_W (TAG_W),
         .SHIFT (stage_shift(LOG2N, k))
      ) u_stage (
         .clk        (Clk),
         .rst        (Reset),
         .up_valid   (valid_s[k]),
         .up_ready   (up_ready),
         .down_ready (down_ready),
         .valid      (valid_s[k+1]),
         .data_in    (data_s[k]),
         .shamt_in   (shamt_s[k]),
         .op_in      (op_s[k]),
         .sign_in    (sign_s[k]),
         .tag_in     (tag_s[k]),
         .data_out   (data_s[k+1]),
         .shamt_out  (shamt_s[k+1]),
         .op_out     (op_s[k+1]),
         .sign_out   (sign_s[k+1]),
         .tag_out    (tag_s[k+1])
      );
   end

   assign In_Ready  = g_stage[0].up_ready;
   assign Out_Valid = valid_s[LOG2N];
   assign Result    = data_s[LOG2N];
   assign Out_Tag   = tag_s[LOG2N];

   // Zero is qualified by valid so an empty pipe never reports a zero result.
   assign Zero = valid_s[LOG2N] && (data_s[LOG2N] == '0);

   // Control fields leaving the last stage have no consumer.
   logic unused_tail_bits;
   assign unused_tail_bits = ^{shamt_s[LOG2N], op_s[LOG2N], sign_s[LOG2N]};

endmodule
